usb2phydig_tx: RTL and testbench
================================

Name: usb2phydig_tx

Overview:
- Transmit datapath of the USB2 PHY digital block. Runs in the analog serial-clock domain.
- Takes UTMI TX words (8- or 16-bit), prepends SYNC, serialises LSB-first, bit-stuffs, NRZI-encodes and appends EOP.
- Drives phy_tx_sdata and the analog driver enable.
- Generalises the first-generation 8-bit-only TX interface to parametrised width, SYNC/EOP length and all four UTMI opmodes.

Parameters:
- DATA_W, 8, UTMI data width; legal values 8 or 16.
- SYNC_LEN, 32, SYNC length in bits: SYNC_LEN-1 raw 0s, then one raw 1.
- EOP_LEN, 8, EOP length in bits: raw 0, then EOP_LEN-1 raw 1s; stuffing disabled.
- STUFF_RUN, 6, number of consecutive raw 1s after which a 0 is inserted.

Ports:
- phy_sclk  in  1  serial bit clock; one line bit per cycle
- reset  in  1  asynchronous, active-high reset
- utmi_opmode  in  2  00 normal, 01 non-driving, 10 stuff+NRZI disabled, 11 no SYNC/EOP, stuffing disabled
- utmi_datain  in  DATA_W  TX word
- utmi_tx_valid  in  1  TX valid
- utmi_tx_validh  in  1  high byte valid; used only when DATA_W=16
- utmi_tx_ready  out  1  word accepted this cycle
- phy_tx_sdata  out  1  NRZI line level; 1 = J/idle
- phy_tx_en  out  1  analog driver enable

Behaviour:
- Clocking/reset: one clock, phy_sclk; reset is asynchronous and active-high.
- Reset values: phy_tx_sdata=1, phy_tx_en=0, utmi_tx_ready=0, FSM=IDLE, ones counter 0.
- Reset asserted mid-packet: the packet is aborted immediately (asynchronously); no EOP is sent.
- Output timing: phy_tx_sdata and phy_tx_en are registered. utmi_tx_ready is combinational: utmi_tx_valid AND load slot.
- FSM states: IDLE, SYNC, DATA, EOP.
- IDLE:
  - utmi_opmode is sampled and latched for the whole packet.
  - If utmi_tx_valid=1 and opmode != 01: go to SYNC (opmodes 00/10) or DATA (opmode 11).
  - In opmode 11 the first word is loaded in this IDLE cycle (ready=1). Its first bit appears the next cycle.
  - Opmode 01: utmi_tx_valid ignored; ready stays 0.
- SYNC:
  - Emits SYNC_LEN bits. The first SYNC bit appears on the cycle after valid was sampled (latency 1).
  - On the last SYNC bit: if valid=1, ready=1 and the word is loaded; go to DATA.
  - If valid=0 on the last SYNC bit: go to EOP (zero-length packet).
- DATA:
  - Shifts the word LSB-first. Word length is DATA_W, or 8 if DATA_W=16 and utmi_tx_validh=0 at load.
  - On the last bit of a word (no stuff pending): valid=1 loads the next word (ready=1, back-to-back, no gap); valid=0 goes to EOP (00/10) or IDLE (11).
- EOP: emits EOP_LEN bits with stuffing disabled, then IDLE.
- phy_tx_en: 1 from the first SYNC/DATA bit through the last EOP/DATA bit, 0 otherwise. On returning to IDLE, sdata is forced to 1.
- Bit stuffing (opmode 00 only):
  - The ones counter increments on each raw 1 and clears on a raw 0 or a stuff bit. It carries across SYNC→DATA.
  - When the counter hits STUFF_RUN, the next cycle emits a stuffed 0, and the shifter and the ready slot stall one cycle.
  - A stuff bit is still inserted when the run completes on the final data bit, before EOP.
- NRZI (opmodes 00 and 11): raw 0 toggles sdata; raw 1 holds it.
- Opmode 10: raw bits go to the line directly, without NRZI or stuffing.

Optional Feature:
- Macro: USB2PHYDIG_TX_LONG_EOP_EN.
- Defined: if the low byte of the first word is the SOF PID 8'hA5, the EOP for that packet is 40 bits (raw 0 + 39 ones).
- Undefined: every EOP is EOP_LEN bits, and no PID compare logic is present.

Decomposition:
- Package usb2phydig_pkg holds:
  - FSM state enum
  - opmode encodings
  - SOF_PID=8'hA5
  - LONG_EOP_LEN=40
  - J level constant
- Sub-module usb2phydig_nrzi_stuff:
  - Inputs: raw bit, stuff_en, nrzi_en, restart.
  - Outputs: registered line bit and a stall flag back to the serialiser.

Test Plan:
- DATA_W=8, opmode 00, one word 8'hFF:
  - SYNC = 31 toggles then a hold.
  - A stuff bit is inserted after the 5th data bit.
  - en is high for exactly 32+9+8=49 cycles.
  - ready pulses once, on cycle 32.
- DATA_W=16, words 16'h1234 (validh=1) then 16'h0056 (validh=0):
  - 16+8 data bits, back-to-back.
  - ready is asserted on exactly 2 cycles, 16 cycles apart.
- Opmode 11, word 8'h00: no SYNC/EOP; sdata toggles 8 times; en high for 8 cycles; first bit 1 cycle after valid.
- Opmode 10, word 8'h7E with a 6-ones run: raw bits 0,1,1,1,1,1,1,0 appear on sdata verbatim, with no stuff bit.
- Reset mid-DATA (cycle 40): en=0 and sdata=1 immediately. Next valid restarts cleanly with a full SYNC.
- With USB2PHYDIG_TX_LONG_EOP_EN defined, word 8'hA5: EOP lasts 40 cycles. With any other PID: EOP lasts 8 cycles.

Source files
------------

// File: rtl/usb2phydig_pkg.sv
// Shared types and constants for the USB2 PHY digital TX path.
package usb2phydig_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SYNC,
        ST_DATA,
        ST_EOP
    } tx_state_t;

    localparam logic [1:0] OPMODE_NORMAL  = 2'b00;
    localparam logic [1:0] OPMODE_NODRIVE = 2'b01;
    localparam logic [1:0] OPMODE_NOSTUFF = 2'b10;
    localparam logic [1:0] OPMODE_NOSYNC  = 2'b11;

    localparam logic [7:0]  SOF_PID      = 8'hA5;
    localparam int unsigned LONG_EOP_LEN = 40;
    localparam logic        LINE_J       = 1'b1;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/usb2phydig_nrzi_stuff.sv
// Line encoder: bit stuffing and NRZI, with the ones-run counter and the
// registered line level. Raises o_stall while a stuff bit is due.
module usb2phydig_nrzi_stuff
    import usb2phydig_pkg::*;
#(
    parameter int unsigned STUFF_RUN = 6
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_raw,
    input  logic i_stuff_en,
    input  logic i_nrzi_en,
    input  logic i_restart,
    output logic o_line,
    output logic o_stall
);
    localparam int unsigned ONES_W = $clog2(STUFF_RUN + 1);
    localparam logic [ONES_W-1:0] RUN_MAX = ONES_W'(STUFF_RUN);

    logic [ONES_W-1:0] r_ones;
    logic              r_line;

    // r_ones counts the run up to and including the bit now on the line.
    assign o_stall = i_stuff_en && (r_ones == RUN_MAX);
    assign o_line  = r_line;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_line <= LINE_J;
            r_ones <= '0;
        end else if (i_restart) begin
            r_line <= LINE_J;
            r_ones <= '0;
        end else if (o_stall) begin
            r_line <= ~r_line;
            r_ones <= '0;
        end else begin
            r_line <= i_nrzi_en ? (i_raw ? r_line : ~r_line) : i_raw;
            if (!i_raw) begin
                r_ones <= '0;
            end else if (r_ones != RUN_MAX) begin
                r_ones <= r_ones + ONES_W'(1);
            end
        end
    end

endmodule

// File: rtl/usb2phydig_tx.sv
// USB2 PHY TX datapath: SYNC, LSB-first data, bit stuffing, NRZI, EOP.
// Optional macro USB2PHYDIG_TX_LONG_EOP_EN: 40-bit EOP after an SOF PID.
module usb2phydig_tx
    import usb2phydig_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned SYNC_LEN  = 32,
    parameter int unsigned EOP_LEN   = 8,
    parameter int unsigned STUFF_RUN = 6
) (
    input  logic              phy_sclk,
    input  logic              reset,
    input  logic [1:0]        utmi_opmode,
    input  logic [DATA_W-1:0] utmi_datain,
    input  logic              utmi_tx_valid,
    input  logic              utmi_tx_validh,
    output logic              utmi_tx_ready,
    output logic              phy_tx_sdata,
    output logic              phy_tx_en
);
    localparam int unsigned CNT_W = $clog2(max3(SYNC_LEN, EOP_LEN, LONG_EOP_LEN) + 1);
    localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_LEN - 1);

    tx_state_t         r_state;
    logic [1:0]        r_opmode;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_shift;
    logic              r_wide;
    logic              r_en;

    tx_state_t         w_state_nxt;
    logic [1:0]        w_opmode_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [CNT_W-1:0]  w_cnt_inc;
    logic [DATA_W-1:0] w_shift_nxt;
    logic              w_wide_nxt;
    logic              w_raw;
    logic              w_load;
    logic              w_stall;
    logic              w_restart;
    logic              w_stuff_en;
    logic              w_nrzi_en;
    logic              w_line;
    logic [CNT_W-1:0]  w_word_last;
    logic [CNT_W-1:0]  w_eop_last;

`ifdef USB2PHYDIG_TX_LONG_EOP_EN
    logic r_long_eop;
    logic w_long_nxt;
    assign w_eop_last = r_long_eop ? CNT_W'(LONG_EOP_LEN - 1) : CNT_W'(EOP_LEN - 1);
`else
    assign w_eop_last = CNT_W'(EOP_LEN - 1);
`endif

    assign w_cnt_inc   = r_cnt + CNT_W'(1);
    assign w_word_last = r_wide ? CNT_W'(15) : CNT_W'(7);

    // The FSM position names the bit currently on the line; the encoder
    // loads the raw bit of the next position, so state and line stay aligned.
    always_comb begin
        w_state_nxt  = r_state;
        w_opmode_nxt = r_opmode;
        w_cnt_nxt    = r_cnt;
        w_shift_nxt  = r_shift;
        w_wide_nxt   = r_wide;
        w_raw        = LINE_J;
        w_load       = 1'b0;
`ifdef USB2PHYDIG_TX_LONG_EOP_EN
        w_long_nxt   = r_long_eop;
`endif
        case (r_state)
            ST_IDLE: begin
                if (utmi_tx_valid && (utmi_opmode != OPMODE_NODRIVE)) begin
                    w_opmode_nxt = utmi_opmode;
                    w_cnt_nxt    = '0;
`ifdef USB2PHYDIG_TX_LONG_EOP_EN
                    w_long_nxt   = 1'b0;
`endif
                    if (utmi_opmode == OPMODE_NOSYNC) begin
                        w_load      = 1'b1;
                        w_state_nxt = ST_DATA;
                    end else begin
                        w_state_nxt = ST_SYNC;
                        w_raw       = (SYNC_LAST == '0);
                    end
                end
            end
            ST_SYNC: begin
                if (!w_stall) begin
                    if (r_cnt == SYNC_LAST) begin
                        if (utmi_tx_valid) begin
                            w_load      = 1'b1;
                            w_state_nxt = ST_DATA;
`ifdef USB2PHYDIG_TX_LONG_EOP_EN
                            w_long_nxt  = (utmi_datain[7:0] == SOF_PID);
`endif
                        end else begin
                            w_state_nxt = ST_EOP;
                            w_cnt_nxt   = '0;
                            w_raw       = 1'b0;
                        end
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                        w_raw     = (w_cnt_inc == SYNC_LAST);
                    end
                end
            end
            ST_DATA: begin
                if (!w_stall) begin
                    if (r_cnt == w_word_last) begin
                        if (utmi_tx_valid) begin
                            w_load = 1'b1;
                        end else if (r_opmode == OPMODE_NOSYNC) begin
                            w_state_nxt = ST_IDLE;
                        end else begin
                            w_state_nxt = ST_EOP;
                            w_cnt_nxt   = '0;
                            w_raw       = 1'b0;
                        end
                    end else begin
                        w_shift_nxt = r_shift >> 1;
                        w_cnt_nxt   = w_cnt_inc;
                        w_raw       = r_shift[1];
                    end
                end
            end
            ST_EOP: begin
                if (r_cnt == w_eop_last) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                    w_raw     = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (w_load) begin
            w_shift_nxt = utmi_datain;
            w_cnt_nxt   = '0;
            w_wide_nxt  = (DATA_W == 16) && utmi_tx_validh;
            w_raw       = utmi_datain[0];
        end
    end

    assign w_restart     = (w_state_nxt == ST_IDLE);
    assign w_stuff_en    = ((r_state == ST_SYNC) || (r_state == ST_DATA)) &&
                           (r_opmode == OPMODE_NORMAL);
    assign w_nrzi_en     = (w_opmode_nxt != OPMODE_NOSTUFF);
    assign utmi_tx_ready = w_load;
    assign phy_tx_sdata  = w_line;
    assign phy_tx_en     = r_en;

    always_ff @(posedge phy_sclk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_opmode <= OPMODE_NORMAL;
            r_cnt    <= '0;
            r_shift  <= '0;
            r_wide   <= 1'b0;
            r_en     <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_opmode <= w_opmode_nxt;
            r_cnt    <= w_cnt_nxt;
            r_shift  <= w_shift_nxt;
            r_wide   <= w_wide_nxt;
            r_en     <= (w_state_nxt != ST_IDLE);
        end
    end

`ifdef USB2PHYDIG_TX_LONG_EOP_EN
    always_ff @(posedge phy_sclk or posedge reset) begin
        if (reset) begin
            r_long_eop <= 1'b0;
        end else begin
            r_long_eop <= w_long_nxt;
        end
    end
`endif

    usb2phydig_nrzi_stuff #(
        .STUFF_RUN (STUFF_RUN)
    ) u_line (
        .i_clk      (phy_sclk),
        .i_rst      (reset),
        .i_raw      (w_raw),
        .i_stuff_en (w_stuff_en),
        .i_nrzi_en  (w_nrzi_en),
        .i_restart  (w_restart),
        .o_line     (w_line),
        .o_stall    (w_stall)
    );

endmodule

// File: tb/tb_usb2phydig_tx.sv
// Bench for usb2phydig_tx: packet-level model (bit lists, stuffing, NRZI)
// checked every cycle, plus literal per-packet expectations.
`timescale 1ns/1ps
module tb_usb2phydig_tx;
    localparam int SYNC_LEN  = 32;
    localparam int EOP_LEN   = 8;
    localparam int STUFF_RUN = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]  op8, op16;
    logic [7:0]  d8;
    logic [15:0] d16;
    logic        v8, v16, vh8, vh16;
    logic        rdy8, rdy16, sd8, sd16, en8, en16;

    usb2phydig_tx #(.DATA_W(8)) dut8 (
        .phy_sclk(clk), .reset(rst), .utmi_opmode(op8), .utmi_datain(d8),
        .utmi_tx_valid(v8), .utmi_tx_validh(vh8), .utmi_tx_ready(rdy8),
        .phy_tx_sdata(sd8), .phy_tx_en(en8)
    );

    usb2phydig_tx #(.DATA_W(16)) dut16 (
        .phy_sclk(clk), .reset(rst), .utmi_opmode(op16), .utmi_datain(d16),
        .utmi_tx_valid(v16), .utmi_tx_validh(vh16), .utmi_tx_ready(rdy16),
        .phy_tx_sdata(sd16), .phy_tx_en(en16)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] wq [4];
    logic        wh [4];
    bit          line_q [$];
    int          rdy_q [$];

    int sel = 0;
    bit chk_on = 1'b0;
    bit exp_sd, exp_en, exp_rdy;
    int cyc;
    int en_seen, rdy_seen, tog_seen, rdy_first, rdy_last;
    bit prev_sd;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            logic a_sd, a_en, a_rdy;
            a_sd  = (sel == 1) ? sd16  : sd8;
            a_en  = (sel == 1) ? en16  : en8;
            a_rdy = (sel == 1) ? rdy16 : rdy8;
            chk($sformatf("sdata@c%0d", cyc), a_sd, exp_sd);
            chk($sformatf("en@c%0d", cyc), a_en, exp_en);
            chk($sformatf("ready@c%0d", cyc), a_rdy, exp_rdy);
            if (a_en) en_seen++;
            if (a_rdy) begin
                if (rdy_seen == 0) rdy_first = cyc;
                rdy_last = cyc;
                rdy_seen++;
            end
            if (cyc != 0 && a_sd != prev_sd) tog_seen++;
            prev_sd = a_sd;
        end
    end

    function automatic bit line_of(input bit prev, input bit r, input logic [1:0] opm);
        if (opm == 2'b10) return r;
        return r ? prev : ~prev;
    endfunction

    // Expected line levels for cycles 1..N and the cycle each word is accepted.
    task automatic build_model(input int s, input logic [1:0] opm, input int nw);
        bit raw [$];
        bit cnt [$];
        int ws [$];
        int eop_len, run, len, k;
        bit lvl;
        line_q.delete();
        rdy_q.delete();
        if (opm == 2'b01) return;
        if (opm != 2'b11)
            for (int i = 0; i < SYNC_LEN; i++) begin
                raw.push_back(i == SYNC_LEN - 1);
                cnt.push_back(1'b1);
            end
        for (int w = 0; w < nw; w++) begin
            ws.push_back(raw.size());
            len = (s == 1 && wh[w]) ? 16 : 8;
            for (int b = 0; b < len; b++) begin
                raw.push_back(wq[w][b]);
                cnt.push_back(1'b1);
            end
        end
        if (opm != 2'b11) begin
            eop_len = EOP_LEN;
`ifdef USB2PHYDIG_TX_LONG_EOP_EN
            if (nw > 0 && wq[0][7:0] == 8'hA5) eop_len = 40;
`endif
            for (int i = 0; i < eop_len; i++) begin
                raw.push_back(i != 0);
                cnt.push_back(1'b0);
            end
        end
        run = 0;
        lvl = 1'b1;
        k = 0;
        for (int i = 0; i < raw.size(); i++) begin
            if (k < ws.size() && ws[k] == i) begin
                rdy_q.push_back(line_q.size());
                k++;
            end
            lvl = line_of(lvl, raw[i], opm);
            line_q.push_back(lvl);
            if (opm == 2'b00 && cnt[i]) begin
                run = raw[i] ? run + 1 : 0;
                if (run == STUFF_RUN) begin
                    lvl = line_of(lvl, 1'b0, opm);
                    line_q.push_back(lvl);
                    run = 0;
                end
            end
        end
    endtask

    task automatic drive(input int s, input logic [1:0] opm, input logic v,
                         input logic [15:0] d, input logic h);
        if (s == 0) begin
            op8 = opm; v8 = v; d8 = d[7:0]; vh8 = h;
        end else begin
            op16 = opm; v16 = v; d16 = d; vh16 = h;
        end
    endtask

    task automatic idle();
        op8 = 2'b00; v8 = 1'b0; d8 = '0; vh8 = 1'b0;
        op16 = 2'b00; v16 = 1'b0; d16 = '0; vh16 = 1'b0;
    endtask

    task automatic run_packet(input int s, input logic [1:0] opm, input int nw,
                              input int lit_en, input int lit_rdy, input int abort_at);
        int n, last_rdy, k;
        logic v;
        build_model(s, opm, nw);
        n = (opm == 2'b01) ? 10 : line_q.size();
        last_rdy = (rdy_q.size() > 0) ? rdy_q[rdy_q.size() - 1] : 0;
        sel = s;
        en_seen = 0; rdy_seen = 0; tog_seen = 0; rdy_first = -1; rdy_last = -1;
        for (int c = 0; c <= n + 3; c++) begin
            @(posedge clk);
            #1;
            k = 0;
            while (k < rdy_q.size() && rdy_q[k] < c) k++;
            if (opm == 2'b01) v = (c < n);
            else v = (c == 0) || (rdy_q.size() > 0 && c <= last_rdy);
            drive(s, opm, v, (k < nw) ? wq[k] : 16'h0000, (k < nw) ? wh[k] : 1'b0);
            cyc = c;
            exp_en = (c >= 1 && c <= line_q.size());
            if (exp_en) exp_sd = line_q[c - 1];
            else exp_sd = 1'b1;
            exp_rdy = 1'b0;
            foreach (rdy_q[i]) if (rdy_q[i] == c) exp_rdy = 1'b1;
            chk_on = 1'b1;
            if (c == abort_at) begin
                chk_on = 1'b0;
                #2 rst = 1'b1;
                #1;
                chk("abort_en", (s == 1) ? en16 : en8, 0);
                chk("abort_sdata", (s == 1) ? sd16 : sd8, 1);
                @(posedge clk);
                #1 rst = 1'b0;
                idle();
                @(posedge clk);
                #1;
                return;
            end
        end
        @(posedge clk);
        #1;
        chk_on = 1'b0;
        idle();
        chk("en_cycles", en_seen, lit_en);
        chk("ready_cycles", rdy_seen, lit_rdy);
    endtask

    initial begin
        idle();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sdata8", sd8, 1);   chk("rst_en8", en8, 0);   chk("rst_ready8", rdy8, 0);
        chk("rst_sdata16", sd16, 1); chk("rst_en16", en16, 0); chk("rst_ready16", rdy16, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 8'hFF, normal mode: stuff after 5th data bit, 32+9+8 enabled cycles
        wq[0] = 16'h00FF; wh[0] = 1'b0;
        run_packet(0, 2'b00, 1, 49, 1, -1);
        chk("ff_ready_cycle", rdy_first, 32);

        // 16-bit then 8-bit word, back to back
        wq[0] = 16'h1234; wh[0] = 1'b1; wq[1] = 16'h0056; wh[1] = 1'b0;
        run_packet(1, 2'b00, 2, 64, 2, -1);
        chk("w16_ready_first", rdy_first, 32);
        chk("w16_ready_gap", rdy_last - rdy_first, 16);

        // opmode 11: no SYNC/EOP, 8 toggles
        wq[0] = 16'h0000; wh[0] = 1'b0;
        run_packet(0, 2'b11, 1, 8, 1, -1);
        chk("op11_ready_cycle", rdy_first, 0);
        chk("op11_toggles", tog_seen, 8);

        // opmode 10: raw bits verbatim, no stuff bit
        wq[0] = 16'h007E;
        run_packet(0, 2'b10, 1, 48, 1, -1);
        chk("op10_toggles", tog_seen, 6);

        // run completes on last bit of first word: ready slips to the stuff cycle
        wq[0] = 16'h00FC; wq[1] = 16'h0001; wh[1] = 1'b0;
        run_packet(0, 2'b00, 2, 57, 2, -1);
        chk("stall_ready_first", rdy_first, 32);
        chk("stall_ready_last", rdy_last, 41);

        // stuff bit before EOP
        wq[0] = 16'h00FC;
        run_packet(0, 2'b00, 1, 49, 1, -1);

        // zero-length packet
        run_packet(0, 2'b00, 0, 40, 0, -1);

        // non-driving: valid ignored
        wq[0] = 16'h00FF;
        run_packet(0, 2'b01, 1, 0, 0, -1);

        // opmode 11, 16-bit word of ones: no stuffing
        wq[0] = 16'hFFFF; wh[0] = 1'b1;
        run_packet(1, 2'b11, 1, 16, 1, -1);

        // reset mid-DATA, then a clean restart
        wq[0] = 16'h00FF; wh[0] = 1'b0;
        run_packet(0, 2'b00, 1, 0, 0, 40);
        run_packet(0, 2'b00, 1, 49, 1, -1);
        chk("restart_ready_cycle", rdy_first, 32);

        // SOF PID vs other PID
        wq[0] = 16'h00A5;
`ifdef USB2PHYDIG_TX_LONG_EOP_EN
        run_packet(0, 2'b00, 1, 80, 1, -1);
`else
        run_packet(0, 2'b00, 1, 48, 1, -1);
`endif
        wq[0] = 16'h005A;
        run_packet(0, 2'b00, 1, 48, 1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
